mem_store_buffer: RTL and testbench

Store buffer and load/store sequencer sitting between the EX/MEM pipeline register and the 16-bit data memory. It accepts load and store requests from the pipeline and queues stores in a small FIFO. Stores drain to memory in the background. Loads are served by forwarding from the youngest matching queued store, or by a memory read, and return a registered load result toward the MEM/WB register.

---
 rtl/cpu_pipe_pkg.sv | 25 ++
 rtl/mem_store_buffer_if.sv | 61 ++++++
 rtl/mem_store_buffer_fifo.sv | 92 +++++++++
 rtl/mem_store_buffer.sv | 143 ++++++++++++++
 tb/tb_mem_store_buffer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_pipe_pkg
// Shared widths, load-sequencer states and store-entry layout for the MEM stage.
// Rev     : 1.0
// ============================================================================
package cpu_pipe_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2
    } ls_state_e;

    // Default-width store entry; modules with non-default widths build their own.
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } sb_entry_t;

endpackage : cpu_pipe_pkg
`default_nettype wire

// File: rtl/mem_store_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_store_buffer_if
// Pipeline request/load-return channel plus the data-memory bus of the store buffer.
// Rev       : 1.0
// ============================================================================
interface mem_store_buffer_if
    import cpu_pipe_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          load_valid;
    logic [DW-1:0] load_data;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_readout;

    // Environment side: pipeline requester and data memory.
    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  load_valid,
        input  load_data,
        input  mem_addr,
        input  mem_wdata,
        input  mem_read,
        input  mem_write,
        output mem_readout
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output load_valid,
        output load_data,
        output mem_addr,
        output mem_wdata,
        output mem_read,
        output mem_write,
        input  mem_readout
    );

endinterface : mem_store_buffer_if
`default_nettype wire

// File: rtl/mem_store_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module : store_buffer_fifo
// Circular store queue with head/tail/count and a youngest-match address search.
// Rev    : 1.0
// ============================================================================
module store_buffer_fifo
    import cpu_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_push,
    input  wire logic [AW-1:0]            i_push_addr,
    input  wire logic [DW-1:0]            i_push_data,
    input  wire logic                     i_pop,
    input  wire logic [AW-1:0]            i_lookup_addr,
    output logic                          o_hit,
    output logic [DW-1:0]                 o_hit_data,
    output logic [AW-1:0]                 o_head_addr,
    output logic [DW-1:0]                 o_head_data,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = c_pw + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [c_pw-1:0]   r_head;
    logic [c_pw-1:0]   r_tail;
    logic [c_cw-1:0]   r_count;

    logic              w_hit;
    logic [DW-1:0]     w_hit_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + c_pw'(1);
            end
            if (i_pop) begin
                r_head <= r_head + c_pw'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only entries inside [head, head+count) are ever read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= '{addr: i_push_addr, data: i_push_data};
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [c_pw-1:0] idx;
            idx = r_head + c_pw'(i);
            if ((c_cw'(i) < r_count) && (r_mem[idx].addr == i_lookup_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_mem[idx].data;
            end
        end
    end

    assign o_hit       = w_hit;
    assign o_hit_data  = w_hit_data;
    assign o_head_addr = r_mem[r_head].addr;
    assign o_head_data = r_mem[r_head].data;
    assign o_count     = r_count;

endmodule : store_buffer_fifo
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module : mem_store_buffer
// Store buffer and load/store sequencer between EX/MEM and the data memory.
// Rev    : 1.0
// ============================================================================
module mem_store_buffer
    import cpu_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    mem_store_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0]    sb_count,
    output logic                      sb_empty
);

    localparam int c_cw = $clog2(DEPTH) + 1;

    localparam logic [1:0] c_st_idle = IDLE;
    localparam logic [1:0] c_st_rd   = RD;
    localparam logic [1:0] c_st_wait = WAIT;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_load_valid;
    logic [DW-1:0]    r_load_data;

    logic             w_load_busy;
    logic             w_full;
    logic             w_ready;
    logic             w_accept;
    logic             w_store_acc;
    logic             w_load_acc;
    logic             w_hit_acc;
    logic             w_miss_acc;
    logic             w_pop;

    logic             w_hit;
    logic [DW-1:0]    w_hit_data;
    logic [AW-1:0]    w_head_addr;
    logic [DW-1:0]    w_head_data;
    logic [c_cw-1:0]  w_count;

    store_buffer_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_store_acc),
        .i_push_addr   (bus.req_addr),
        .i_push_data   (bus.req_wdata),
        .i_pop         (w_pop),
        .i_lookup_addr (bus.req_addr),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_count       (w_count)
    );

    // Ready depends only on registered state, never on the incoming request.
    assign w_load_busy = (r_state != c_st_idle);
    assign w_full      = (w_count == c_cw'(DEPTH));
    assign w_ready     = !w_load_busy && !w_full;

    assign w_accept    = bus.req_valid && w_ready;
    assign w_store_acc = w_accept && bus.req_write;
    assign w_load_acc  = w_accept && !bus.req_write;
    assign w_hit_acc   = w_load_acc && w_hit;
    assign w_miss_acc  = w_load_acc && !w_hit;

    // A missing load owns the memory port on its accept edge; drain waits.
    assign w_pop       = (r_state == c_st_idle) && (w_count != '0) && !w_miss_acc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_miss_acc) w_state_nxt = c_st_rd;
            c_st_rd:   w_state_nxt = c_st_wait;
            c_st_wait: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_st_idle;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_load_valid <= 1'b0;

            if (w_miss_acc) begin
                r_mem_read <= 1'b1;
                r_mem_addr <= bus.req_addr;
            end else if (w_pop) begin
                r_mem_write <= 1'b1;
                r_mem_addr  <= w_head_addr;
                r_mem_wdata <= w_head_data;
            end

            // Memory data is valid during WAIT; capture it on the edge that leaves WAIT.
            if (w_hit_acc) begin
                r_load_valid <= 1'b1;
                r_load_data  <= w_hit_data;
            end else if (r_state == c_st_wait) begin
                r_load_valid <= 1'b1;
                r_load_data  <= bus.mem_readout;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.load_valid = r_load_valid;
    assign bus.load_data  = r_load_data;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;

    assign sb_count = w_count;
    assign sb_empty = (w_count == '0);

endmodule : mem_store_buffer
`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_store_buffer
// Scoreboard bench: program-order memory model predicts every load and drain write.
// Rev    : 1.0
// ============================================================================
module tb_mem_store_buffer;

    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [$clog2(DEPTH):0]   sb_count;
    logic                     sb_empty;

    mem_store_buffer_if #(.AW(16), .DW(16)) sb_if ();

    mem_store_buffer #(
        .DEPTH (DEPTH),
        .AW    (16),
        .DW    (16)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (sb_if),
        .sb_count (sb_count),
        .sb_empty (sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
        int          kind;   // 0 = must hit, 1 = must miss, 2 = either
    } ld_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          collide = 0;
    int          cnt_err = 0;
    int          last_rd_cyc = -10;
    int          last_wr_cyc = -10;
    logic [15:0] last_rd_addr = '0;
    logic [15:0] last_wr_addr = '0;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    ld_t         ldq[$];
    wr_t         wrq[$];

    function automatic logic [15:0] init_val(int a);
        return (a == 50) ? 16'h1234 : 16'(a * 7 + 256);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Data memory: write commits at the edge ending the strobe cycle; read data one cycle later.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        sb_if.mem_readout = '0;
        forever begin
            @(posedge clk);
            if (sb_if.mem_write) mem[sb_if.mem_addr[7:0]] <= sb_if.mem_wdata;
            if (sb_if.mem_read) sb_if.mem_readout <= mem[sb_if.mem_addr[7:0]];
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write or a load result.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (sb_if.mem_read && sb_if.mem_write) collide++;
                if ((sb_count > DEPTH) || (sb_empty != (sb_count == 0))) cnt_err++;
                if (sb_if.mem_read) begin
                    last_rd_cyc  = cyc;
                    last_rd_addr = sb_if.mem_addr;
                end
                if (sb_if.mem_write) begin
                    last_wr_cyc  = cyc;
                    last_wr_addr = sb_if.mem_addr;
                    if (wrq.size() == 0) begin
                        chk("unexpected_mem_write", 1, 0);
                    end else begin
                        wr_t w;
                        w = wrq.pop_front();
                        chk("drain_addr", int'(sb_if.mem_addr), int'(w.addr));
                        chk("drain_data", int'(sb_if.mem_wdata), int'(w.data));
                    end
                end
                if (sb_if.load_valid) begin
                    if (ldq.size() == 0) begin
                        chk("spurious_load_valid", 1, 0);
                    end else begin
                        ld_t e;
                        int  lat;
                        e   = ldq.pop_front();
                        lat = cyc - e.cyc;
                        chk("load_data", int'(sb_if.load_data), int'(e.data));
                        if (e.kind == 0)      chk("hit_latency", lat, 1);
                        else if (e.kind == 1) chk("miss_latency", lat, 3);
                        else                  chk("load_latency_1_or_3", int'(lat == 1 || lat == 3), 1);
                        if (lat == 3) begin
                            chk("miss_read_cycle", last_rd_cyc, e.cyc + 1);
                            chk("miss_read_addr", int'(last_rd_addr), int'(e.addr));
                        end else begin
                            chk("hit_without_read", int'(last_rd_cyc > e.cyc), 0);
                        end
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic drive(input logic w, input logic [15:0] a, input logic [15:0] d, input int kind);
        int budget;
        budget = 0;
        sb_if.req_valid = 1'b1;
        sb_if.req_write = w;
        sb_if.req_addr  = a;
        sb_if.req_wdata = d;
        while (!sb_if.req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!sb_if.req_ready) begin
            chk("req_ready_timeout", 0, 1);
            sb_if.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (w) begin
            ref_mem[a[7:0]] = d;
            wrq.push_back('{addr: a, data: d});
        end else begin
            ldq.push_back('{addr: a, data: ref_mem[a[7:0]], cyc: cyc, kind: kind});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sb_if.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_all();
        int budget;
        budget = 0;
        sb_if.req_valid = 1'b0;
        while ((ldq.size() != 0 || !sb_empty || wrq.size() != 0) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_read"},   int'(sb_if.mem_read), 0);
        chk({tag, "_mem_write"},  int'(sb_if.mem_write), 0);
        chk({tag, "_mem_addr"},   int'(sb_if.mem_addr), 0);
        chk({tag, "_mem_wdata"},  int'(sb_if.mem_wdata), 0);
        chk({tag, "_load_valid"}, int'(sb_if.load_valid), 0);
        chk({tag, "_load_data"},  int'(sb_if.load_data), 0);
        chk({tag, "_sb_empty"},   int'(sb_empty), 1);
        chk({tag, "_sb_count"},   int'(sb_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        sb_if.req_valid = 1'b0;
        sb_if.req_write = 1'b0;
        sb_if.req_addr  = '0;
        sb_if.req_wdata = '0;

        #1;
        check_reset_state("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("por_req_ready", int'(sb_if.req_ready), 1);

        // Store then immediate load of the same address forwards.
        drive(1'b1, 16'd1, 16'd5, 0);
        drive(1'b0, 16'd1, 16'd0, 0);
        // Youngest of two same-address stores is forwarded.
        drive(1'b1, 16'd2, 16'h000A, 0);
        drive(1'b1, 16'd2, 16'h000B, 0);
        drive(1'b0, 16'd2, 16'd0, 0);
        drain_all();

        // Load miss on an empty queue.
        drive(1'b0, 16'd50, 16'd0, 1);
        sb_if.req_valid = 1'b0;
        chk("miss_mem_read_e0", int'(sb_if.mem_read), 1);
        chk("miss_mem_addr_e0", int'(sb_if.mem_addr), 50);
        chk("miss_ready_low_e0", int'(sb_if.req_ready), 0);
        @(negedge clk);
        chk("miss_ready_low_e1", int'(sb_if.req_ready), 0);
        @(negedge clk);
        chk("miss_ready_high_e2", int'(sb_if.req_ready), 1);
        drain_all();

        // Burst of stores queued behind a load miss; read them all back afterwards.
        drive(1'b0, 16'd60, 16'd0, 1);
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, 16'(100 + (i % 4)), 16'(16'hC000 + i), 2);
        drain_all();
        for (int i = 0; i < 4; i++) drive(1'b0, 16'(100 + i), 16'd0, 1);
        drain_all();

        // Load hits an entry on the same edge that entry is popped.
        drive(1'b1, 16'd7, 16'd9, 0);
        drive(1'b0, 16'd7, 16'd0, 0);
        drain_all();
        // Miss with a non-empty queue: the read goes out before the queued write.
        drive(1'b1, 16'd4, 16'h0044, 2);
        drive(1'b0, 16'd3, 16'd0, 1);
        drain_all();
        chk("read_before_write_order", int'(last_wr_cyc > last_rd_cyc), 1);
        chk("read_before_write_addr", int'(last_wr_addr), 4);

        // Reset mid-traffic discards queued stores and the in-flight load.
        drive(1'b1, 16'd10, 16'hAA10, 2);
        drive(1'b1, 16'd11, 16'hAA11, 2);
        drive(1'b0, 16'd90, 16'd0, 1);
        sb_if.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        ldq.delete();
        wrq.delete();
        ref_mem = mem;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_req_ready", int'(sb_if.req_ready), 1);
        drive(1'b0, 16'd11, 16'd0, 1);
        drive(1'b0, 16'd10, 16'd0, 1);
        drain_all();

        // Randomized traffic over a small address set to provoke hits and misses.
        for (int n = 0; n < 300; n++) begin
            logic        w;
            logic [15:0] a;
            logic [15:0] d;
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 15));
            d = 16'($urandom);
            drive(w, a, d, 2);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain_all();

        for (int i = 0; i < 128; i++) chk("final_mem", int'(mem[i]), int'(ref_mem[i]));
        chk("rd_wr_collision_cycles", collide, 0);
        chk("count_invariant_errors", cnt_err, 0);
        chk("leftover_writes", wrq.size(), 0);
        chk("leftover_loads", ldq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_store_buffer
`default_nettype wire
